// File: rtl/sdf_bitrev_reorder_pkg.sv
// sdf_bitrev_reorder_pkg: shared sample width and read FSM state type
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

package sdf_bitrev_reorder_pkg;
    localparam int DW = `DATA_IN_WIDTH;
    typedef enum logic {RD_IDLE, RD_READ} rd_state_t;
endpackage

// File: rtl/sdf_bitrev_reorder_ram.sv
// sdf_bitrev_reorder_ram: simple dual-port RAM with one write port and a registered synchronous read port
module sdf_bitrev_reorder_ram #(
    parameter int AW = 7,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [AW-1:0] ra,
    input  logic [W-1:0]  wd,
    output logic [W-1:0]  q
);
    logic [W-1:0] mem [2**AW];
    // write port and registered read port; the bank being read is never written
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        q <= mem[ra];
    end
endmodule

// File: rtl/sdf_bitrev_reorder.sv
// sdf_bitrev_reorder: ping-pong buffer turning a bit-reversed frame stream into natural order
module sdf_bitrev_reorder
    import sdf_bitrev_reorder_pkg::*;
#(
    parameter int LOG2_N = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          di_en,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    output logic          do_en,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im
);
    typedef logic [LOG2_N-1:0] idx_t;

    function automatic idx_t bitrev(input idx_t x);
        idx_t r;
        r = '0;
        for (int i = 0; i < LOG2_N; i++) r[i] = x[LOG2_N-1-i];
        return r;
    endfunction

    idx_t        wr_cnt, rd_cnt;
    logic        wr_bank, rd_bank, frame_done;
    rd_state_t   state;
    logic        rd;
    logic [LOG2_N:0]  wr_addr, rd_addr;
    logic [2*DW-1:0]  q;

    // a finished frame starts its burst immediately with slot 0 of the just-filled bank
    assign rd      = frame_done | (state == RD_READ);
    assign wr_addr = {wr_bank, wr_cnt};
    assign rd_addr = frame_done ? {~wr_bank, idx_t'(0)} : {rd_bank, bitrev(rd_cnt)};
    assign do_re   = do_en ? q[2*DW-1:DW] : '0;
    assign do_im   = do_en ? q[DW-1:0] : '0;

    sdf_bitrev_reorder_ram #(.AW(LOG2_N + 1), .W(2 * DW)) u_ram (
        .clk (clk),
        .we  (di_en & ~reset),
        .wa  (wr_addr),
        .ra  (rd_addr),
        .wd  ({di_re, di_im}),
        .q   (q)
    );

    // write counter, bank swap and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= di_en & (&wr_cnt);
            if (di_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (&wr_cnt) wr_bank <= ~wr_bank;
            end
        end
    end

    // read FSM: slot 0 is read on frame_done, the remaining N-1 slots follow in READ
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            do_en   <= 1'b0;
        end else begin
            do_en <= rd;
            if (frame_done) begin
                state   <= RD_READ;
                rd_bank <= ~wr_bank;
                rd_cnt  <= idx_t'(1);
            end else if (state == RD_READ) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (&rd_cnt) state <= RD_IDLE;
            end
        end
    end
endmodule

// File: doc/sdf_bitrev_reorder.md
Name: sdf_bitrev_reorder

Overview:
Output reorder buffer that consumes the bit-reversed-order sample stream from the last R2SDF stage and re-emits each N-point frame in natural order. It is the reader-side counterpart of the SDF pipeline: the SDF stages write X[bitrev(n)] in slot n, and this block reads it back as X[k] in slot k. Ping-pong double buffering gives continuous throughput. It sits between the final SdfUnit stage and the FFT top-level output.

Parameters:
LOG2_N, 6, log2 of FFT length N (N = 2**LOG2_N; legal 3..10)
`DATA_IN_WIDTH (define.v), 16, sample width per real/imag component; global macro, not a module parameter

Ports:
clk  input  1  master clock, rising edge
reset  input  1  synchronous, active-high reset
di_en  input  1  input sample valid
di_re  input  DATA_IN_WIDTH  input data, real, bit-reversed order
di_im  input  DATA_IN_WIDTH  input data, imag, bit-reversed order
do_en  output  1  output sample valid
do_re  output  DATA_IN_WIDTH  output data, real, natural order
do_im  output  DATA_IN_WIDTH  output data, imag, natural order

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All state updates on rising clk.
- Reset values: do_en=0, do_re=0, do_im=0. wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, read FSM in IDLE. RAM contents are not cleared.
- Storage: 2 banks x N entries, each DATA_IN_WIDTH*2 wide. Address = {bank, index}.
- Write side:
  - On each cycle with di_en=1: mem[{wr_bank, wr_cnt}] <= {di_re, di_im}, then wr_cnt++.
  - di_en=0 holds wr_cnt. Gaps inside a frame are legal.
  - When a write lands at wr_cnt=N-1: wr_cnt wraps to 0, wr_bank toggles, and a one-cycle frame_done pulse is generated in the next cycle.
- Read FSM:
  - IDLE: on frame_done, go to READ with rd_bank = the just-filled bank and rd_cnt=0.
  - READ, each cycle: issue a synchronous read of mem[{rd_bank, bitrev(rd_cnt)}], where bitrev reverses the LOG2_N bits; then rd_cnt++.
  - After the read with rd_cnt=N-1: if frame_done is asserted in that same cycle, stay in READ with the new bank and rd_cnt=0 (seamless back-to-back). Otherwise return to IDLE.
- Output registers: do_en, do_re and do_im are registered RAM read data, valid one cycle after the read is issued. do_en=1 for exactly N consecutive cycles per frame.
- Latency: the last input sample is written in cycle t; the first output (k=0) has do_en=1 in cycle t+2.
  - With continuous input, latency from first input sample to first output sample is N+1 cycles.
  - Back-to-back frames with continuous di_en produce continuous do_en.
- While do_en=0, do_re/do_im hold 0. The data path is gated with the valid register, not left at stale RAM data.
- No overflow is possible:
  - A read burst takes exactly N cycles.
  - The next frame needs at least N write cycles before the bank swap.
  - The bank being read is therefore never overwritten during its burst. No backpressure port exists.
- Simultaneous events: a write of the final sample in the same cycle as the last read of the previous frame is legal and is handled by the seamless transition above.
- Reset mid-operation:
  - The partial input frame and any in-progress output burst are discarded.
  - do_en drops to 0 in the cycle after reset is sampled.
  - The first frame after reset starts at wr_cnt=0 in bank 0.

Decomposition:
- define.v: DATA_IN_WIDTH (existing). No new globals are needed. LOG2_N stays a local parameter, and a bitrev function is local to the module.
- Sub-module reorder_ram: simple dual-port RAM, depth 2*N, width 2*DATA_IN_WIDTH, one write port, one synchronous read port with registered output. This keeps it inferable as block RAM.
- The top level holds the counters, bank flags, read FSM and output gating.

Test Plan:
1. LOG2_N=3, one frame with di_re = slot index 0..7 and di_im = 100+slot, di_en continuous:
   - do_re sequence must be 0,4,2,6,1,5,3,7 and do_im must be 100 plus the same values.
   - do_en must be high for exactly 8 cycles, with the first output 2 cycles after the last input.
2. LOG2_N=3, three frames back-to-back (frame f uses values 16f+slot):
   - do_en must stay high for 24 consecutive cycles.
   - Each frame must be bit-reverse reordered, with no sample loss or duplication at the boundaries.
3. LOG2_N=3, one frame with di_en toggling 1,0,1,0 (gaps):
   - Output must be identical to scenario 1.
   - The output burst must still be 8 contiguous do_en cycles, starting 2 cycles after the 8th valid input.
4. Reset asserted for 1 cycle after 5 samples of a frame, then a full fresh frame of values 0..7:
   - do_en must stay 0 until the fresh frame completes.
   - Output must be 0,4,2,6,1,5,3,7 with no stale samples.
5. Reset asserted mid output burst (after 3 outputs):
   - do_en=0 and do_re/do_im=0 from the next cycle.
   - The next complete frame must be reordered correctly.
6. LOG2_N=6, random complex data, 10 continuous frames:
   - A scoreboard must check do[k] == di[bitrev6(k)] for every frame.
   - Latency from first input to first output must be 65 cycles.
